// File: rtl/relu_requant_pack.sv
// relu_requant_pack: per-lane round/shift/saturate of a 7x32b ReLU beat to 7x8b, packed 4 beats per 224b word.
// Latency: a packed word appears on out_* one cycle after its completing beat is accepted.
// Backpressure: single output buffer; in_ready = !out_valid || out_ready, so no beat is taken while a word is held.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   shift[4:0]              right-shift amount, sampled at each accepted beat
//   in_valid/in_ready       input beat handshake; in_data lane i at [i*IW +: IW]; in_last flushes a partial word
//   out_valid/out_ready     packed word handshake; out_data beat k lane i at [k*56 + i*8 +: 8]
//   out_keep[3:0]           bit k set = beat slot k holds data; out_last = word holds the tile's final beat
//   sat_cnt[15:0]           saturating count of saturated lanes (only when RELU_PACK_STATS_EN is defined)
// Optional feature macro: RELU_PACK_STATS_EN
module relu_requant_pack #(
    parameter int LANES = 7,
    parameter int IW    = 32,
    parameter int OW    = 8,
    parameter int DW    = 224
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    shift,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_keep,
    output logic          out_last
`ifdef RELU_PACK_STATS_EN
    ,
    output logic [15:0]   sat_cnt
`endif
);

    localparam int          BW  = LANES * OW;  // packed width of one beat
    localparam logic [IW:0] ONE = 1;

    logic [IW:0]    w_rnd;
    logic [BW-1:0]  w_beat;
    logic           w_accept;
    logic           w_done;
    logic [DW-1:0]  w_word;
    logic [3:0]     w_keep;

    logic [DW-1:0]  r_pack;
    logic [3:0]     r_keep;
    logic [1:0]     r_cnt;
    logic           r_out_valid;
    logic [DW-1:0]  r_out_data;
    logic [3:0]     r_out_keep;
    logic           r_out_last;

`ifdef RELU_PACK_STATS_EN
    logic [LANES-1:0] w_sat;
    logic [16:0]      w_sat_sum;
    logic [15:0]      r_sat_cnt;
`endif

    // Round-half-up constant shared by all lanes; shift==0 means no rounding.
    assign w_rnd = (shift == 5'd0) ? '0 : (ONE << (shift - 5'd1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IW-1:0] w_x;
        logic [IW:0]   w_sum;
        logic [IW:0]   w_r;
        logic          w_neg;
        logic          w_hi;

        assign w_x   = in_data[g*IW +: IW];
        assign w_neg = w_x[IW-1];
        // One extra bit keeps x + rnd exact for the largest positive x.
        assign w_sum = {1'b0, w_x} + w_rnd;
        assign w_r   = w_sum >> shift;
        assign w_hi  = |w_r[IW:OW];
        assign w_beat[g*OW +: OW] = w_neg ? '0 : (w_hi ? '1 : w_r[OW-1:0]);
`ifdef RELU_PACK_STATS_EN
        assign w_sat[g] = !w_neg && w_hi;
`endif
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_done   = w_accept && ((r_cnt == 2'd3) || in_last);

    // Pack contents including the current beat; unfilled slots stay zero.
    always_comb begin
        w_word = r_pack;
        w_word[32'(r_cnt)*BW +: BW] = w_beat;
        w_keep = r_keep | (4'b0001 << r_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack      <= '0;
            r_keep      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_keep  <= w_keep;
                r_out_last  <= in_last;
                r_pack      <= '0;
                r_keep      <= '0;
                r_cnt       <= '0;
            end else begin
                if (w_accept) begin
                    r_pack <= w_word;
                    r_keep <= w_keep;
                    r_cnt  <= r_cnt + 2'd1;
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

`ifdef RELU_PACK_STATS_EN
    // Worst case 16'hFFFF + 7 fits in 17 bits, so the carry flags saturation.
    assign w_sat_sum = {1'b0, r_sat_cnt} + 17'($countones(w_sat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_accept) begin
            r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule
